reg_write_scoreboard: RTL and testbench

Tracks in-flight writes to the 32-entry general register file so decode can tell whether a source register still awaits a result. Sits beside the register file: the decode stage registers each issued destination, and the writeback stage retires it through the same signals that drive the register file write port. Decode uses the busy outputs to stall. Register 0 is never tracked.

---
 rtl/reg_write_scoreboard_if.sv | 24 ++
 rtl/reg_write_scoreboard.sv | 81 ++++++++
 tb/tb_reg_write_scoreboard.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/reg_write_scoreboard_if.sv
// Decode/writeback handshake bundle for the register write scoreboard.
interface reg_write_scoreboard_if;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic       issue_ready;
  logic       wb_we;
  logic [4:0] wb_a3;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rs_busy;
  logic       rt_busy;
  logic       pending_any;
  logic       err;

  modport master (
    output issue_valid, issue_rd, wb_we, wb_a3, rs, rt,
    input  issue_ready, rs_busy, rt_busy, pending_any, err
  );

  modport slave (
    input  issue_valid, issue_rd, wb_we, wb_a3, rs, rt,
    output issue_ready, rs_busy, rt_busy, pending_any, err
  );
endinterface

// File: rtl/reg_write_scoreboard.sv
// Per-register pending-write counters for decode stall detection.
// Optional macro SCB_WB_BYPASS_EN: a retiring last write reads not-busy in its own cycle.
module reg_write_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  reg_write_scoreboard_if.slave  bus
);

  localparam int unsigned NREG = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_q, err_d;
  logic             pending_any_q, pending_any_d;

  logic issue_ready;
  logic issue_acc;
  logic issue_bad;
  logic retire;
  logic same_reg;
  logic rs_byp, rt_byp;

  // A retire to the same register frees a slot even when saturated.
  assign issue_ready = (bus.issue_rd == 5'd0) || (cnt_q[bus.issue_rd] != CNT_MAX) ||
                       (bus.wb_we && (bus.wb_a3 == bus.issue_rd));
  assign issue_acc   = bus.issue_valid && (bus.issue_rd != 5'd0) && issue_ready;
  assign issue_bad   = bus.issue_valid && !issue_ready;
  assign retire      = bus.wb_we && (bus.wb_a3 != 5'd0);
  assign same_reg    = issue_acc && retire && (bus.wb_a3 == bus.issue_rd);

  always_comb begin
    cnt_d         = cnt_q;
    err_d         = err_q;
    pending_any_d = 1'b0;
    if (flush) begin
      for (int i = 0; i < NREG; i++) cnt_d[i] = '0;
    end else begin
      if (issue_acc && !same_reg)
        cnt_d[bus.issue_rd] = cnt_q[bus.issue_rd] + CNT_ONE;
      if (retire && !same_reg && (cnt_q[bus.wb_a3] != '0))
        cnt_d[bus.wb_a3] = cnt_q[bus.wb_a3] - CNT_ONE;
      if (issue_bad || (retire && !same_reg && (cnt_q[bus.wb_a3] == '0)))
        err_d = 1'b1;
    end
    cnt_d[0] = '0;
    for (int i = 1; i < NREG; i++) pending_any_d = pending_any_d | (cnt_d[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      err_q         <= 1'b0;
      pending_any_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      pending_any_q <= pending_any_d;
    end
  end

`ifdef SCB_WB_BYPASS_EN
  // Register file forwards WD, so the last retiring write is already visible.
  assign rs_byp = bus.wb_we && (bus.wb_a3 == bus.rs) && (cnt_q[bus.rs] == CNT_ONE);
  assign rt_byp = bus.wb_we && (bus.wb_a3 == bus.rt) && (cnt_q[bus.rt] == CNT_ONE);
`else
  assign rs_byp = 1'b0;
  assign rt_byp = 1'b0;
`endif

  assign bus.rs_busy     = (bus.rs != 5'd0) && (cnt_q[bus.rs] != '0) && !rs_byp;
  assign bus.rt_busy     = (bus.rt != 5'd0) && (cnt_q[bus.rt] != '0) && !rt_byp;
  assign bus.issue_ready = issue_ready;
  assign bus.pending_any = pending_any_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed bench for reg_write_scoreboard (CNT_W=2), hand-computed expectations.
module tb_reg_write_scoreboard;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_chk  = 0;
  int   n_pass = 0;

`ifdef SCB_WB_BYPASS_EN
  localparam logic RETIRE_BUSY = 1'b0;
`else
  localparam logic RETIRE_BUSY = 1'b1;
`endif

  reg_write_scoreboard_if bus ();

  reg_write_scoreboard #(.CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.wb_we       = 1'b0;
    flush           = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
    bus.wb_we = 1'b0; bus.wb_a3 = 5'd0;
    bus.rs = 5'd0; bus.rt = 5'd0;
    repeat (2) tick();
    reset = 1'b0;

    // Idle after reset
    bus.rs = 5'd5; bus.issue_rd = 5'd5; settle();
    chk("rst_rs_busy", bus.rs_busy, 1'b0);
    chk("rst_ready", bus.issue_ready, 1'b1);
    chk("rst_pending", bus.pending_any, 1'b0);
    chk("rst_err", bus.err, 1'b0);

    // Issue r8, retire three cycles later
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd8; bus.rs = 5'd8; bus.rt = 5'd8; settle();
    chk("r8_pre_busy", bus.rs_busy, 1'b0);
    tick(); idle(); settle();
    chk("r8_c2_rs", bus.rs_busy, 1'b1);
    chk("r8_c2_rt", bus.rt_busy, 1'b1);
    chk("r8_c2_pend", bus.pending_any, 1'b1);
    tick();
    chk("r8_c3_rs", bus.rs_busy, 1'b1);
    bus.wb_we = 1'b1; bus.wb_a3 = 5'd8; settle();
    chk("r8_c4_rs", bus.rs_busy, RETIRE_BUSY);
    chk("r8_c4_rt", bus.rt_busy, RETIRE_BUSY);
    chk("r8_c4_pend", bus.pending_any, 1'b1);
    tick(); idle(); settle();
    chk("r8_c5_rs", bus.rs_busy, 1'b0);
    chk("r8_c5_pend", bus.pending_any, 1'b0);
    chk("r8_c5_err", bus.err, 1'b0);

    // Saturate r3
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3; bus.rs = 5'd3;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("r3_ready_%0d", i), bus.issue_ready, 1'b1);
      tick();
    end
    bus.issue_valid = 1'b0; settle();
    chk("r3_full_ready", bus.issue_ready, 1'b0);
    chk("r3_full_busy", bus.rs_busy, 1'b1);
    bus.issue_valid = 1'b1; bus.wb_we = 1'b1; bus.wb_a3 = 5'd3; settle();
    chk("r3_same_ready", bus.issue_ready, 1'b1);
    tick(); idle(); settle();
    chk("r3_same_err", bus.err, 1'b0);
    chk("r3_same_full", bus.issue_ready, 1'b0);
    bus.issue_valid = 1'b1;
    tick(); idle(); settle();
    chk("r3_force_err", bus.err, 1'b1);
    chk("r3_force_full", bus.issue_ready, 1'b0);
    // Drain r3: 3 -> 2 -> 1 -> 0
    bus.wb_we = 1'b1; bus.wb_a3 = 5'd3;
    tick();
    chk("r3_cnt2_busy", bus.rs_busy, 1'b1);
    tick();
    chk("r3_cnt1_busy", bus.rs_busy, RETIRE_BUSY);
    tick(); idle(); settle();
    chk("r3_cnt0_busy", bus.rs_busy, 1'b0);
    chk("r3_cnt0_pend", bus.pending_any, 1'b0);
    chk("r3_err_hold", bus.err, 1'b1);

    reset = 1'b1; tick(); reset = 1'b0; settle();
    chk("rst2_err", bus.err, 1'b0);

    // Register 0 is never tracked
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.wb_we = 1'b1; bus.wb_a3 = 5'd0; bus.rs = 5'd0;
    repeat (3) tick();
    chk("r0_busy", bus.rs_busy, 1'b0);
    chk("r0_pend", bus.pending_any, 1'b0);
    chk("r0_err", bus.err, 1'b0);
    chk("r0_ready", bus.issue_ready, 1'b1);
    idle();

    // Retire of an idle register
    bus.wb_we = 1'b1; bus.wb_a3 = 5'd9; bus.rs = 5'd9; settle();
    chk("r9_pre_err", bus.err, 1'b0);
    tick(); idle(); settle();
    chk("r9_err", bus.err, 1'b1);
    chk("r9_busy", bus.rs_busy, 1'b0);
    chk("r9_pend", bus.pending_any, 1'b0);
    repeat (3) tick();
    chk("r9_err_hold", bus.err, 1'b1);

    // r4, r5 pending; then issue r7 while retiring r5
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; tick();
    bus.issue_rd = 5'd5; tick(); idle();
    bus.rs = 5'd4; bus.rt = 5'd5; settle();
    chk("r4_busy", bus.rs_busy, 1'b1);
    chk("r5_busy", bus.rt_busy, 1'b1);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.wb_we = 1'b1; bus.wb_a3 = 5'd5;
    tick(); idle();
    bus.rs = 5'd7; settle();
    chk("r7_busy", bus.rs_busy, 1'b1);
    chk("r5_retired", bus.rt_busy, 1'b0);
    chk("r7_err", bus.err, 1'b1);

    // Flush with a concurrent issue
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; tick();
    flush = 1'b1; bus.issue_rd = 5'd6; tick(); idle();
    bus.rs = 5'd4; bus.rt = 5'd5; settle();
    chk("fl_r4", bus.rs_busy, 1'b0);
    chk("fl_r5", bus.rt_busy, 1'b0);
    bus.rs = 5'd6; bus.rt = 5'd7; settle();
    chk("fl_r6", bus.rs_busy, 1'b0);
    chk("fl_r7", bus.rt_busy, 1'b0);
    chk("fl_pend", bus.pending_any, 1'b0);
    chk("fl_err_held", bus.err, 1'b1);

    reset = 1'b1; tick(); reset = 1'b0; settle();
    chk("rst3_err", bus.err, 1'b0);
    chk("rst3_pend", bus.pending_any, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
